lod_decode16: RTL and testbench

Reassembles a word-level leading-one result from a stream of 4-bit leading-one detector codes, one nibble code per beat, most-significant nibble first. It is the decode side of the nibble detector: it turns (hotflag, 2-bit index) beats back into a one-hot mask and a binary bit index for the full word. It sits downstream of the nibble detector stage and feeds normalisation/shift logic through a valid/ready handshake.

---
 rtl/lod_decode16.sv | 129 ++++++++++++
 tb/tb_lod_decode16.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lod_decode16.sv
// lod_decode16 - reassembles a word-level leading-one result from a stream of
// per-nibble leading-one detector codes, most-significant nibble first.
//
// Ports:
//   aclk, aresetn        clock (rising edge), asynchronous active-low reset
//   rx_valid / rx_ready  beat handshake; a beat is taken when both are high
//   rx_hotflag           nibble contained a one
//   rx_data[1:0]         leading-one position inside the nibble (3 = MSB)
//   rx_last              final beat of word marker
//   tx_valid / tx_ready  result handshake
//   tx_data[W-1:0]       one-hot mask of the word's leading one (0 if none)
//   tx_index[IW-1:0]     bit index of the leading one (0 if none)
//   tx_hotflag           word contained a one
//   tx_error             rx_last disagreed with the beat count for the word
module lod_decode16 #(
    parameter  int unsigned NIBBLES = 4,
    localparam int unsigned W       = 4 * NIBBLES,
    localparam int unsigned IW      = $clog2(W),
    localparam int unsigned KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          rx_valid,
    output logic          rx_ready,
    input  logic          rx_hotflag,
    input  logic [1:0]    rx_data,
    input  logic          rx_last,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [W-1:0]  tx_data,
    output logic [IW-1:0] tx_index,
    output logic          tx_hotflag,
    output logic          tx_error
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t        state_q;
    logic [KW-1:0] k_q;
    logic          hot_q;
    logic [IW-1:0] idx_q;
    logic          rx_ready_q;
    logic          tx_valid_q;
    logic [W-1:0]  tx_data_q;
    logic [IW-1:0] tx_index_q;
    logic          tx_hotflag_q;
    logic          tx_error_q;

    logic          accept;
    logic          last_pos;
    logic          word_end;
    logic [IW-1:0] beat_idx;
    logic          hot_d;
    logic [IW-1:0] idx_d;

    // rx_ready_q is only ever high in COLLECT, so it doubles as the state gate.
    assign accept   = rx_valid && rx_ready_q;
    assign last_pos = (k_q == KW'(NIBBLES - 1));
    assign word_end = last_pos || rx_last;

    // Accumulator values including the current beat; the first hot beat wins.
    always_comb begin
        beat_idx = IW'(4 * (NIBBLES - 1 - int'(k_q)) + int'(rx_data));
        hot_d    = hot_q || rx_hotflag;
        idx_d    = hot_q ? idx_q : (rx_hotflag ? beat_idx : '0);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= COLLECT;
            k_q          <= '0;
            hot_q        <= 1'b0;
            idx_q        <= '0;
            rx_ready_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            tx_index_q   <= '0;
            tx_hotflag_q <= 1'b0;
            tx_error_q   <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    rx_ready_q <= 1'b1;
                    if (accept) begin
                        if (word_end) begin
                            tx_index_q   <= idx_d;
                            tx_data_q    <= hot_d ? (W'(1) << idx_d) : '0;
                            tx_hotflag_q <= hot_d;
                            tx_error_q   <= (rx_last != last_pos);
                            k_q          <= '0;
                            hot_q        <= 1'b0;
                            idx_q        <= '0;
                            rx_ready_q   <= 1'b0;
                            tx_valid_q   <= 1'b1;
                            state_q      <= HOLD;
                        end else begin
                            k_q   <= k_q + KW'(1);
                            hot_q <= hot_d;
                            idx_q <= idx_d;
                        end
                    end
                end
                HOLD: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        rx_ready_q <= 1'b1;
                        state_q    <= COLLECT;
                    end
                end
                default: begin
                    state_q    <= COLLECT;
                    rx_ready_q <= 1'b0;
                    tx_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready   = rx_ready_q;
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign tx_index   = tx_index_q;
    assign tx_hotflag = tx_hotflag_q;
    assign tx_error   = tx_error_q;

endmodule

// File: tb/tb_lod_decode16.sv
// tb_lod_decode16 - directed self-checking bench for lod_decode16.
module tb_lod_decode16;

    logic        aclk       = 1'b0;
    logic        aresetn    = 1'b0;
    logic        rx_valid   = 1'b0;
    logic        rx_hotflag = 1'b0;
    logic [1:0]  rx_data    = 2'd0;
    logic        rx_last    = 1'b0;
    logic        tx_ready   = 1'b0;
    logic        rx_ready;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic [3:0]  tx_index;
    logic        tx_hotflag;
    logic        tx_error;

    // {tx_valid, tx_hotflag, tx_data, tx_index, tx_error}
    logic [22:0] obs;
    assign obs = {tx_valid, tx_hotflag, tx_data, tx_index, tx_error};

    int total = 0;
    int bad   = 0;

    lod_decode16 #(.NIBBLES(4)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_hotflag (rx_hotflag),
        .rx_data    (rx_data),
        .rx_last    (rx_last),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_index   (tx_index),
        .tx_hotflag (tx_hotflag),
        .tx_error   (tx_error)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Present one beat once rx_ready is seen, hold it across one edge.
    task automatic beat(input logic h, input logic [1:0] d, input logic l);
        int n = 0;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(posedge aclk); #1;
            n++;
        end
        if (n == 20) begin
            total++; bad++;
            $display("FAIL beat_wait rx_ready=%b required=1", rx_ready);
        end
        rx_valid = 1'b1; rx_hotflag = h; rx_data = d; rx_last = l;
        @(posedge aclk); #1;
        rx_valid = 1'b0; rx_hotflag = 1'b0; rx_data = 2'd0; rx_last = 1'b0;
    endtask

    task automatic consume();
        tx_ready = 1'b1;
        @(posedge aclk); #1;
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({obs, rx_ready} !== 24'h0) begin
            bad++;
            $display("FAIL reset_out obs=%h rdy=%b required obs=0 rdy=0", obs, rx_ready);
        end
        @(posedge aclk); #2;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        total++;
        if ({obs, rx_ready} !== {23'h0, 1'b1}) begin
            bad++;
            $display("FAIL reset_release obs=%h rdy=%b required obs=0 rdy=1", obs, rx_ready);
        end
    endtask

    task automatic test_zero_word();
        beat(1'b0, 2'd0, 1'b0); beat(1'b0, 2'd0, 1'b0);
        beat(1'b0, 2'd0, 1'b0); beat(1'b0, 2'd0, 1'b1);
        total++;
        if (obs !== {1'b1, 1'b0, 16'h0000, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL zero_word obs=%h required=%h", obs, {1'b1, 1'b0, 16'h0000, 4'd0, 1'b0});
        end
        consume();
        total++;
        if ({tx_valid, rx_ready} !== 2'b01) begin
            bad++;
            $display("FAIL zero_consume valid/rdy=%b%b required=01", tx_valid, rx_ready);
        end
    endtask

    task automatic test_first_hot_wins();
        beat(1'b0, 2'd0, 1'b0); beat(1'b1, 2'd3, 1'b0);
        beat(1'b1, 2'd1, 1'b0); beat(1'b0, 2'd0, 1'b1);
        total++;
        if (obs !== {1'b1, 1'b1, 16'h0800, 4'd11, 1'b0}) begin
            bad++;
            $display("FAIL word_0a30 obs=%h required=%h", obs, {1'b1, 1'b1, 16'h0800, 4'd11, 1'b0});
        end
        consume();
    endtask

    task automatic test_extremes();
        beat(1'b0, 2'd0, 1'b0); beat(1'b0, 2'd0, 1'b0);
        beat(1'b0, 2'd0, 1'b0); beat(1'b1, 2'd0, 1'b1);
        total++;
        if (obs !== {1'b1, 1'b1, 16'h0001, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL word_0001 obs=%h required=%h", obs, {1'b1, 1'b1, 16'h0001, 4'd0, 1'b0});
        end
        consume();
        beat(1'b1, 2'd3, 1'b0); beat(1'b1, 2'd2, 1'b0);
        beat(1'b0, 2'd0, 1'b0); beat(1'b1, 2'd1, 1'b1);
        total++;
        if (obs !== {1'b1, 1'b1, 16'h8000, 4'd15, 1'b0}) begin
            bad++;
            $display("FAIL word_8000 obs=%h required=%h", obs, {1'b1, 1'b1, 16'h8000, 4'd15, 1'b0});
        end
        consume();
    endtask

    task automatic test_backpressure();
        beat(1'b0, 2'd0, 1'b0); beat(1'b0, 2'd0, 1'b0);
        beat(1'b1, 2'd0, 1'b0); beat(1'b0, 2'd0, 1'b1);
        // Offer a hot beat during HOLD; it must be refused.
        rx_valid = 1'b1; rx_hotflag = 1'b1; rx_data = 2'd3; rx_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({obs, rx_ready} !== {1'b1, 1'b1, 16'h0010, 4'd4, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL hold_stable cyc=%0d obs=%h rdy=%b required obs=%h rdy=0",
                         i, obs, rx_ready, {1'b1, 1'b1, 16'h0010, 4'd4, 1'b0});
            end
            @(posedge aclk); #1;
        end
        rx_valid = 1'b0; rx_hotflag = 1'b0; rx_data = 2'd0; rx_last = 1'b0;
        consume();
        total++;
        if ({tx_valid, rx_ready} !== 2'b01) begin
            bad++;
            $display("FAIL bp_release valid/rdy=%b%b required=01", tx_valid, rx_ready);
        end
        beat(1'b0, 2'd0, 1'b0); beat(1'b1, 2'd2, 1'b0);
        beat(1'b0, 2'd0, 1'b0); beat(1'b1, 2'd3, 1'b1);
        total++;
        if (obs !== {1'b1, 1'b1, 16'h0400, 4'd10, 1'b0}) begin
            bad++;
            $display("FAIL bp_next obs=%h required=%h", obs, {1'b1, 1'b1, 16'h0400, 4'd10, 1'b0});
        end
        consume();
    endtask

    task automatic test_last_errors();
        beat(1'b1, 2'd2, 1'b0); beat(1'b0, 2'd0, 1'b1);
        total++;
        if (obs !== {1'b1, 1'b1, 16'h4000, 4'd14, 1'b1}) begin
            bad++;
            $display("FAIL early_last obs=%h required=%h", obs, {1'b1, 1'b1, 16'h4000, 4'd14, 1'b1});
        end
        consume();
        // Must restart at nibble 3: hot on 4th beat lands in nibble 0.
        beat(1'b0, 2'd0, 1'b0); beat(1'b0, 2'd0, 1'b0);
        beat(1'b0, 2'd0, 1'b0); beat(1'b1, 2'd1, 1'b1);
        total++;
        if (obs !== {1'b1, 1'b1, 16'h0002, 4'd1, 1'b0}) begin
            bad++;
            $display("FAIL after_early obs=%h required=%h", obs, {1'b1, 1'b1, 16'h0002, 4'd1, 1'b0});
        end
        consume();
        beat(1'b0, 2'd0, 1'b0); beat(1'b1, 2'd0, 1'b0);
        beat(1'b0, 2'd0, 1'b0); beat(1'b0, 2'd0, 1'b0);
        total++;
        if (obs !== {1'b1, 1'b1, 16'h0100, 4'd8, 1'b1}) begin
            bad++;
            $display("FAIL missing_last obs=%h required=%h", obs, {1'b1, 1'b1, 16'h0100, 4'd8, 1'b1});
        end
        consume();
    endtask

    task automatic test_gaps();
        beat(1'b0, 2'd0, 1'b0);
        // Invalid cycles carrying hot data must not count or latch.
        rx_hotflag = 1'b1; rx_data = 2'd3;
        repeat (3) @(posedge aclk);
        #1;
        rx_hotflag = 1'b0; rx_data = 2'd0;
        beat(1'b0, 2'd0, 1'b0);
        total++;
        if (tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL gap_no_early valid=%b required=0", tx_valid);
        end
        beat(1'b1, 2'd3, 1'b0); beat(1'b0, 2'd0, 1'b1);
        total++;
        if (obs !== {1'b1, 1'b1, 16'h0080, 4'd7, 1'b0}) begin
            bad++;
            $display("FAIL gap_word obs=%h required=%h", obs, {1'b1, 1'b1, 16'h0080, 4'd7, 1'b0});
        end
        consume();
    endtask

    task automatic test_reset_mid_word();
        beat(1'b1, 2'd3, 1'b0); beat(1'b0, 2'd0, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        total++;
        if ({obs, rx_ready} !== 24'h0) begin
            bad++;
            $display("FAIL mid_reset obs=%h rdy=%b required obs=0 rdy=0", obs, rx_ready);
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        total++;
        if ({obs, rx_ready} !== {23'h0, 1'b1}) begin
            bad++;
            $display("FAIL mid_release obs=%h rdy=%b required obs=0 rdy=1", obs, rx_ready);
        end
        beat(1'b0, 2'd0, 1'b0); beat(1'b0, 2'd0, 1'b0);
        beat(1'b1, 2'd2, 1'b0); beat(1'b0, 2'd0, 1'b1);
        total++;
        if (obs !== {1'b1, 1'b1, 16'h0040, 4'd6, 1'b0}) begin
            bad++;
            $display("FAIL post_reset obs=%h required=%h", obs, {1'b1, 1'b1, 16'h0040, 4'd6, 1'b0});
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_zero_word();
        test_first_hot_wins();
        test_extremes();
        test_backpressure();
        test_last_errors();
        test_gaps();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
